// File: rtl/i2c_tx_fifo_pkg.sv
// Shared constants for the I2C FIFO and the I2C master controller.
// Holds the default word/address widths and the controller state encodings
// so both blocks agree on widths.
package i2c_tx_fifo_pkg;

    localparam int unsigned I2C_DATA_WIDTH      = 8;
    localparam int unsigned I2C_FIFO_ADDR_WIDTH = 4;

    // Controller state encodings (consumed by the I2C master controller).
    localparam int unsigned I2C_STATE_WIDTH = 2;
    localparam logic [1:0]  I2C_ST_IDLE     = 2'd0;
    localparam logic [1:0]  I2C_ST_START    = 2'd1;
    localparam logic [1:0]  I2C_ST_TX       = 2'd2;
    localparam logic [1:0]  I2C_ST_RX       = 2'd3;

endpackage : i2c_tx_fifo_pkg

// File: rtl/i2c_fifo_ram.sv
// Simple dual-port RAM, 2**ADDR_WIDTH x DATA_WIDTH, for the I2C FIFO.
// Ports:
//   clk           - clock, rising edge
//   we/waddr/wdata - synchronous write port
//   re/raddr       - synchronous read request
//   rdata          - registered read data, updated only when re=1, no reset
module i2c_fifo_ram
    import i2c_tx_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = I2C_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; same-address read+write returns the old word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : i2c_fifo_ram

// File: rtl/i2c_tx_fifo.sv
// Synchronous FIFO buffering bytes between the host interface and the I2C
// master controller (also reused as the RX FIFO).
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   write     - push request, data_in stored when accepted
//   data_in   - write data
//   read      - pop request
//   data_out  - read data, valid the cycle after an accepted read
//   empty     - count == 0
//   full      - count == 2**ADDR_WIDTH
//   count     - occupancy 0..2**ADDR_WIDTH
//   overflow  - one-cycle pulse, write rejected because full
//   underflow - one-cycle pulse, read rejected because empty
module i2c_tx_fifo
    import i2c_tx_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = I2C_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  wr_en;
    logic                  rd_en;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Accept decisions on pre-edge state; a full FIFO still takes a write
    // when a read frees a slot on the same edge.
    always_comb begin
        wr_en = write & (~full | read);
        rd_en = read & ~empty;
    end

    // Next occupancy.
    always_comb begin
        count_next = count;
        unique case ({wr_en, rd_en})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count, flags and error strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                out_valid <= 1'b1;
            end
            count     <= count_next;
            empty     <= (count_next == '0);
            full      <= (count_next == CNT_W'(DEPTH));
            overflow  <= write & full & ~read;
            underflow <= read & empty;
        end
    end

    i2c_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en & ~reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_en & ~reset),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // RAM output is not reset; present zero until the first pop after reset.
    assign data_out = out_valid ? ram_rdata : '0;

endmodule : i2c_tx_fifo

// File: tb/tb_i2c_tx_fifo.sv
// Self-checking bench for i2c_tx_fifo: directed steps with a queue
// scoreboard; every cycle the outputs are compared against a reference model.
module tb_i2c_tx_fifo;

    logic       clk;
    logic       reset;
    logic       write;
    logic [7:0] data_in;
    logic       read;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;

    i2c_tx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .data_in   (data_in),
        .read      (read),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model after an edge.
    task automatic check_all(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(sb.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
        chk({tag, "_full"},  32'(full),  32'(sb.size() == 16));
        chk({tag, "_dout"},  32'(data_out), 32'(exp_dout));
        chk({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
        chk({tag, "_unf"},   32'(underflow), 32'(exp_unf));
    endtask

    // One clock with the given request; model updated from pre-edge state.
    task automatic cycle(input string tag, input logic w, input logic [7:0] d, input logic r);
        bit m_full;
        bit m_empty;
        @(negedge clk);
        reset   = 1'b0;
        write   = w;
        data_in = d;
        read    = r;
        m_full  = (sb.size() == 16);
        m_empty = (sb.size() == 0);
        exp_ovf = w & m_full & ~r;
        exp_unf = r & m_empty;
        if (r && !m_empty) exp_dout = sb.pop_front();
        if (w && (!m_full || r)) sb.push_back(d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        @(negedge clk);
        reset   = 1'b1;
        write   = w;
        data_in = 8'hEE;
        read    = r;
        sb.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;

        // Reset then idle.
        do_reset("rst", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("idle", 1'b0, 8'h00, 1'b0);
        chk("idle_dout_zero", 32'(data_out), 32'h00);

        // Three writes, three spaced reads.
        cycle("w_a5", 1'b1, 8'hA5, 1'b0);
        cycle("w_3c", 1'b1, 8'h3C, 1'b0);
        cycle("w_81", 1'b1, 8'h81, 1'b0);
        chk("three_count", 32'(count), 32'd3);
        cycle("r1", 1'b0, 8'h00, 1'b1);
        chk("r1_val", 32'(data_out), 32'hA5);
        cycle("gap", 1'b0, 8'h00, 1'b0);
        cycle("gap", 1'b0, 8'h00, 1'b0);
        cycle("r2", 1'b0, 8'h00, 1'b1);
        chk("r2_val", 32'(data_out), 32'h3C);
        cycle("gap", 1'b0, 8'h00, 1'b0);
        cycle("gap", 1'b0, 8'h00, 1'b0);
        cycle("r3", 1'b0, 8'h00, 1'b1);
        chk("r3_val", 32'(data_out), 32'h81);
        chk("r3_empty", 32'(empty), 32'd1);

        // Fill (pointers start at 3, so this wraps), overflow, drain.
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        cycle("ovf", 1'b1, 8'hFF, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        cycle("ovf_end", 1'b0, 8'h00, 1'b0);
        chk("ovf_single", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1);
            chk("drain_order", 32'(data_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Read+write while full.
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(i), 1'b0);
        cycle("rw_full", 1'b1, 8'h55, 1'b1);
        chk("rw_full_first", 32'(data_out), 32'h00);
        chk("rw_full_cnt", 32'(count), 32'd16);
        chk("rw_full_noovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 8'h00, 1'b1);
        chk("drain2_last", 32'(data_out), 32'h55);

        // Read+write while empty: no fall-through.
        cycle("rw_empty", 1'b1, 8'h77, 1'b1);
        chk("rw_empty_unf", 32'(underflow), 32'd1);
        chk("rw_empty_dout", 32'(data_out), 32'h55);
        chk("rw_empty_cnt", 32'(count), 32'd1);
        cycle("rd77", 1'b0, 8'h00, 1'b1);
        chk("rd77_val", 32'(data_out), 32'h77);
        cycle("unf_hold", 1'b0, 8'h00, 1'b1);
        cycle("unf_hold", 1'b0, 8'h00, 1'b1);
        cycle("idle", 1'b0, 8'h00, 1'b0);

        // Reset mid-operation with write and read asserted.
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'h40 + i), 1'b0);
        do_reset("mid_rst", 1'b1, 1'b1);
        chk("mid_rst_dout", 32'(data_out), 32'h00);
        chk("mid_rst_cnt", 32'(count), 32'd0);
        cycle("post_w", 1'b1, 8'h99, 1'b0);
        cycle("post_r", 1'b0, 8'h00, 1'b1);
        chk("post_r_val", 32'(data_out), 32'h99);
        cycle("post_idle", 1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_i2c_tx_fifo
